// File: rtl/wb_lms_seq_if.sv
// Wishbone slave bus bundle for the LMS filter peripheral.
// Signal names follow the classic *_i/*_o slave-side port naming.
interface wb_lms_seq_if #(
    parameter int DW = 16
);
    logic          wb_cyc_i;
    logic          wb_stb_i;
    logic          wb_we_i;
    logic [31:0]   wb_adr_i;
    logic [DW-1:0] wb_dat_i;
    logic [DW-1:0] wb_dat_o;
    logic          wb_ack_o;

    modport slave (
        input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i,
        output wb_dat_o, wb_ack_o
    );

    modport master (
        output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i,
        input  wb_dat_o, wb_ack_o
    );
endinterface

// File: rtl/wb_lms_seq.sv
// Wishbone-slave adaptive LMS FIR filter with a sequential one-tap-per-cycle MAC.
// Each X write runs one filter pass and, when training, one coefficient update.
module wb_lms_seq #(
    parameter int DW       = 16,
    parameter int TAPS     = 4,
    parameter int MU_SHIFT = 4
) (
    input  logic          Clk,
    input  logic          Rst,
    wb_lms_seq_if.slave   bus,
    output logic          irq_o
);
    localparam int KW = (TAPS > 1) ? $clog2(TAPS) : 1;
    localparam int AW = 2*DW + KW;
    localparam int SH = DW - 1 + MU_SHIFT;
    localparam logic [DW-1:0] MAXV = {1'b0, {(DW-1){1'b1}}};
    localparam logic [DW-1:0] MINV = {1'b1, {(DW-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_FILTER, S_ERR, S_UPDATE} state_t;
    state_t r_state;

    logic signed [DW-1:0] r_x [TAPS];
    logic signed [DW-1:0] r_w [TAPS];
    logic signed [DW-1:0] r_d, r_y, r_err;
    logic [DW-1:0]        r_count, r_dat;
    logic signed [AW-1:0] r_acc;
    logic [KW-1:0]        r_k;
    logic r_train, r_irq_en, r_pass_train, r_done, r_overrun, r_sat, r_ack, r_irq;

    logic                   w_req, w_busy, w_last, w_wsel;
    logic [7:0]             w_idx;
    logic [5:0]             w_woff;
    logic [KW-1:0]          w_wi;
    logic signed [2*DW-1:0] w_fa, w_fb, w_fprod;
    logic signed [AW-1:0]   w_acc_sh;
    logic                   w_y_sat, w_e_sat, w_w_sat;
    logic signed [DW-1:0]   w_y, w_e, w_wnew;
    logic [DW:0]            w_e_wide;
    logic signed [2*DW-1:0] w_ua, w_ub, w_uprod, w_ush;
    logic [2*DW:0]          w_usum;
    logic [DW-1:0]          w_rdata;
    logic                   w_unused_adr;

    assign w_req  = bus.wb_cyc_i & bus.wb_stb_i & ~r_ack;
    assign w_busy = (r_state != S_IDLE);
    assign w_last = (r_k == KW'(TAPS-1));
    assign w_idx  = bus.wb_adr_i[9:2];
    assign w_woff = w_idx[5:0];
    assign w_wi   = w_woff[KW-1:0];
    assign w_wsel = (w_idx[7:6] == 2'b01) && (32'(w_woff) < 32'(TAPS));
    assign w_unused_adr = ^{bus.wb_adr_i[31:10], bus.wb_adr_i[1:0]};

    // Filter MAC: products sign-extended so the full-width multiply is exact
    assign w_fa     = {{DW{r_w[r_k][DW-1]}}, r_w[r_k]};
    assign w_fb     = {{DW{r_x[r_k][DW-1]}}, r_x[r_k]};
    assign w_fprod  = w_fa * w_fb;

    assign w_acc_sh = r_acc >>> (DW-1);
    assign w_y_sat  = !((&w_acc_sh[AW-1:DW-1]) || !(|w_acc_sh[AW-1:DW-1]));
    assign w_y      = w_y_sat ? (w_acc_sh[AW-1] ? MINV : MAXV) : w_acc_sh[DW-1:0];

    assign w_e_wide = {r_d[DW-1], r_d} - {w_y[DW-1], w_y};
    assign w_e_sat  = w_e_wide[DW] ^ w_e_wide[DW-1];
    assign w_e      = w_e_sat ? (w_e_wide[DW] ? MINV : MAXV) : w_e_wide[DW-1:0];

    // Coefficient update uses the ERR value registered on the ERR-state edge
    assign w_ua     = {{DW{r_err[DW-1]}}, r_err};
    assign w_ub     = {{DW{r_x[r_k][DW-1]}}, r_x[r_k]};
    assign w_uprod  = w_ua * w_ub;
    assign w_ush    = w_uprod >>> SH;
    assign w_usum   = {{(DW+1){r_w[r_k][DW-1]}}, r_w[r_k]} + {w_ush[2*DW-1], w_ush};
    assign w_w_sat  = !((&w_usum[2*DW:DW-1]) || !(|w_usum[2*DW:DW-1]));
    assign w_wnew   = w_w_sat ? (w_usum[2*DW] ? MINV : MAXV) : w_usum[DW-1:0];

    always_comb begin
        w_rdata = '0;
        case (w_idx)
            8'h01:   w_rdata = r_d;
            8'h02:   w_rdata = {{(DW-2){1'b0}}, r_irq_en, r_train};
            8'h03:   w_rdata = {{(DW-4){1'b0}}, r_sat, r_overrun, r_done, w_busy};
            8'h04:   w_rdata = r_y;
            8'h05:   w_rdata = r_err;
            8'h06:   w_rdata = r_count;
            default: if (w_wsel) w_rdata = r_w[w_wi];
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state      <= S_IDLE;
            for (int unsigned i = 0; i < TAPS; i++) begin
                r_x[i] <= '0;
                r_w[i] <= '0;
            end
            r_d          <= '0;
            r_y          <= '0;
            r_err        <= '0;
            r_count      <= '0;
            r_dat        <= '0;
            r_acc        <= '0;
            r_k          <= '0;
            r_train      <= 1'b0;
            r_irq_en     <= 1'b0;
            r_pass_train <= 1'b0;
            r_done       <= 1'b0;
            r_overrun    <= 1'b0;
            r_sat        <= 1'b0;
            r_ack        <= 1'b0;
            r_irq        <= 1'b0;
        end else begin
            r_ack <= w_req;
            r_irq <= r_done & r_irq_en;

            if (w_req) begin
                if (bus.wb_we_i) begin
                    r_dat <= '0;
                    case (w_idx)
                        8'h00: begin
                            if (!w_busy) begin
                                r_x[0] <= bus.wb_dat_i;
                                for (int unsigned i = 1; i < TAPS; i++) r_x[i] <= r_x[i-1];
                                r_pass_train <= r_train;
                                r_acc        <= '0;
                                r_k          <= '0;
                                r_state      <= S_FILTER;
                            end else begin
                                r_overrun <= 1'b1;
                            end
                        end
                        8'h01: r_d <= bus.wb_dat_i;
                        8'h02: begin
                            r_train  <= bus.wb_dat_i[0];
                            r_irq_en <= bus.wb_dat_i[1];
                            if (bus.wb_dat_i[2] && !w_busy)
                                for (int unsigned i = 0; i < TAPS; i++) r_w[i] <= '0;
                        end
                        8'h03: begin
                            if (bus.wb_dat_i[1]) r_done    <= 1'b0;
                            if (bus.wb_dat_i[2]) r_overrun <= 1'b0;
                            if (bus.wb_dat_i[3]) r_sat     <= 1'b0;
                        end
                        default: if (w_wsel && !w_busy) r_w[w_wi] <= bus.wb_dat_i;
                    endcase
                end else begin
                    r_dat <= w_rdata;
                end
            end

            // Placed after the bus decode so a pass-end done set overrides a same-cycle W1C
            case (r_state)
                S_FILTER: begin
                    r_acc <= r_acc + {{(AW-2*DW){w_fprod[2*DW-1]}}, w_fprod};
                    r_k   <= w_last ? '0 : r_k + KW'(1);
                    if (w_last) r_state <= S_ERR;
                end
                S_ERR: begin
                    r_y   <= w_y;
                    r_err <= w_e;
                    if (w_y_sat || w_e_sat) r_sat <= 1'b1;
                    r_k   <= '0;
                    if (r_pass_train) begin
                        r_state <= S_UPDATE;
                    end else begin
                        r_state <= S_IDLE;
                        r_done  <= 1'b1;
                        r_count <= r_count + DW'(1);
                    end
                end
                S_UPDATE: begin
                    r_w[r_k] <= w_wnew;
                    if (w_w_sat) r_sat <= 1'b1;
                    r_k <= w_last ? '0 : r_k + KW'(1);
                    if (w_last) begin
                        r_state <= S_IDLE;
                        r_done  <= 1'b1;
                        r_count <= r_count + DW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.wb_ack_o = r_ack;
    assign bus.wb_dat_o = r_dat;
    assign irq_o        = r_irq;
endmodule
